// File: rtl/act_rdma_pkg.sv
// Shared definitions for the activation read DMA: burst sizing, command layout and FSM encoding.
// The pd pack/unpack helpers describe the default-width command word used by the MCIF arbiter.
package act_rdma_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_BURST_LOG2 = 4;
    localparam int PD_W           = DEF_BURST_LOG2 + 2 * DEF_ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    typedef struct packed {
        logic [DEF_BURST_LOG2-1:0] len;
        logic [DEF_ADDR_W-1:0]     base;
        logic [DEF_ADDR_W-1:0]     addr;
    } rd_cmd_t;

    function automatic int burst_len(input int log2);
        return 1 << log2;
    endfunction

    function automatic logic [PD_W-1:0] pd_pack(input rd_cmd_t cmd);
        return cmd;
    endfunction

    function automatic rd_cmd_t pd_unpack(input logic [PD_W-1:0] pd);
        return pd;
    endfunction

endpackage

// File: rtl/rdma_credit_cnt.sv
// In-flight burst counter: +1 per accepted command, -1 per completed burst, floor at zero.
module rdma_credit_cnt #(
    parameter int MAX_OUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] count_o,
    output logic       has_credit_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       dec_ok;

    // A response with nothing in flight is stale and must not underflow the count.
    assign dec_ok = dec_i && (cnt_q != 8'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_ok) begin
            cnt_d = cnt_q + 8'd1;
        end else if (!inc_i && dec_ok) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o      = cnt_q;
    assign has_credit_o = cnt_q < 8'(MAX_OUT);

endmodule

// File: rtl/act_rdma_3d.sv
// Activation read DMA: walks width bursts, rows and channel groups of a 3-D tensor and issues
// MCIF read commands under an outstanding-burst credit limit, with soft abort.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | emitting commands while credit allows
//   DRAIN | no more commands; waiting for in-flight bursts to complete
//   FIN   | one-cycle done pulse
module act_rdma_3d
    import act_rdma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BURST_LOG2 = 4,
    parameter int BEAT_BYTES = 64,
    parameter int W_W        = 12,
    parameter int H_W        = 12,
    parameter int CHG_W      = 8,
    parameter int MAX_OUT    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [ADDR_W-1:0]              surface_stride,
    input  logic [ADDR_W-1:0]              line_stride,
    input  logic [CHG_W-1:0]               chg_in,
    input  logic [H_W-1:0]                 h_in,
    input  logic [W_W-1:0]                 w_in,
    output logic                           rd_req_vld,
    input  logic                           rd_req_rdy,
    output logic [BURST_LOG2+2*ADDR_W-1:0] rd_req_pd,
    input  logic                           rd_rsp_last,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted,
    output logic [7:0]                     outstanding
);

    localparam int BURST_LEN  = burst_len(BURST_LOG2);
    localparam int BYTE_SHIFT = $clog2(BEAT_BYTES) + BURST_LOG2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d, ss_q, ss_d, ls_q, ls_d;
    logic [ADDR_W-1:0]     row_base_q, row_base_d, ch_base_q, ch_base_d;
    logic [CHG_W-1:0]      c_max_q, c_max_d, c_q, c_d;
    logic [H_W-1:0]        h_max_q, h_max_d, h_q, h_d;
    logic [W_W-1:0]        wb_max_q, wb_max_d, wb_q, wb_d;
    logic [BURST_LOG2-1:0] len_last_q, len_last_d;
    logic                  abort_pend_q, abort_pend_d, aborted_q, aborted_d;

    logic                  has_credit, accept, stop, drain_empty;
    logic                  last_wb, last_h, last_c;
    logic [W_W-1:0]        w_m1;
    logic [BURST_LOG2-1:0] len;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [7:0]            out_cnt;

    rdma_credit_cnt #(.MAX_OUT(MAX_OUT)) u_credit (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_i        (accept),
        .dec_i        (rd_rsp_last),
        .count_o      (out_cnt),
        .has_credit_o (has_credit)
    );

    assign w_m1     = w_in - W_W'(1);
    assign last_wb  = (wb_q == wb_max_q);
    assign last_h   = (h_q == h_max_q);
    assign last_c   = (c_q == c_max_q);
    assign len      = last_wb ? len_last_q : BURST_LOG2'(BURST_LEN - 1);
    assign cmd_addr = row_base_q + (ADDR_W'(wb_q) << BYTE_SHIFT);

    // vld depends only on registered state, so a held command cannot be withdrawn by abort.
    assign rd_req_vld  = (state_q == S_ISSUE) && has_credit;
    assign accept      = rd_req_vld && rd_req_rdy;
    assign stop        = abort || abort_pend_q;
    assign drain_empty = (out_cnt == 8'd0) || ((out_cnt == 8'd1) && rd_rsp_last);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        ss_d         = ss_q;
        ls_d         = ls_q;
        row_base_d   = row_base_q;
        ch_base_d    = ch_base_q;
        c_max_d      = c_max_q;
        c_d          = c_q;
        h_max_d      = h_max_q;
        h_d          = h_q;
        wb_max_d     = wb_max_q;
        wb_d         = wb_q;
        len_last_d   = len_last_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d       = base_addr;
                    ss_d         = surface_stride;
                    ls_d         = line_stride;
                    c_max_d      = chg_in - CHG_W'(1);
                    h_max_d      = h_in - H_W'(1);
                    wb_max_d     = w_m1 >> BURST_LOG2;
                    len_last_d   = w_m1[BURST_LOG2-1:0];
                    c_d          = '0;
                    h_d          = '0;
                    wb_d         = '0;
                    row_base_d   = '0;
                    ch_base_d    = '0;
                    abort_pend_d = 1'b0;
                    aborted_d    = 1'b0;
                    if (chg_in == '0 || h_in == '0 || w_in == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                abort_pend_d = abort_pend_q || abort;
                if (accept) begin
                    if (last_wb) begin
                        wb_d = '0;
                        if (last_h) begin
                            h_d        = '0;
                            c_d        = c_q + CHG_W'(1);
                            ch_base_d  = ch_base_q + ss_q;
                            row_base_d = ch_base_q + ss_q;
                        end else begin
                            h_d        = h_q + H_W'(1);
                            row_base_d = row_base_q + ls_q;
                        end
                    end else begin
                        wb_d = wb_q + W_W'(1);
                    end
                    if ((last_wb && last_h && last_c) || stop) begin
                        state_d = S_DRAIN;
                    end
                end else if (!rd_req_vld && stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                abort_pend_d = abort_pend_q || abort;
                if (drain_empty) begin
                    aborted_d = abort_pend_q || abort;
                    state_d   = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            ss_q         <= '0;
            ls_q         <= '0;
            row_base_q   <= '0;
            ch_base_q    <= '0;
            c_max_q      <= '0;
            c_q          <= '0;
            h_max_q      <= '0;
            h_q          <= '0;
            wb_max_q     <= '0;
            wb_q         <= '0;
            len_last_q   <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            ss_q         <= ss_d;
            ls_q         <= ls_d;
            row_base_q   <= row_base_d;
            ch_base_q    <= ch_base_d;
            c_max_q      <= c_max_d;
            c_q          <= c_d;
            h_max_q      <= h_max_d;
            h_q          <= h_d;
            wb_max_q     <= wb_max_d;
            wb_q         <= wb_d;
            len_last_q   <= len_last_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
        end
    end

    assign rd_req_pd   = {len, base_q, cmd_addr};
    assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done        = (state_q == S_FIN);
    assign aborted     = aborted_q;
    assign outstanding = out_cnt;

endmodule
